// File: rtl/perm_pkg.sv
// Shared constants and state type for the sponge permutation sequencer.
package perm_pkg;

    localparam int unsigned CTR_W      = 5;
    localparam int unsigned MAX_ROUNDS = 12;

    localparam int unsigned ROUNDS_12 = 12;
    localparam int unsigned ROUNDS_8  = 8;
    localparam int unsigned ROUNDS_6  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perm_seq_state_t;

endpackage

// File: rtl/permutation_sequencer.sv
// Initiator-side permutation sequencer: accepts round requests, drives the run and completion pulse.
// Optional counter cross-check built when PERM_SEQ_COUNTER_CHECK_EN is defined.
module permutation_sequencer #(
    parameter int unsigned CTR_W      = perm_pkg::CTR_W,
    parameter int unsigned MAX_ROUNDS = perm_pkg::MAX_ROUNDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CTR_W-1:0] req_rounds,
    input  logic             abort,
    input  logic [CTR_W-1:0] counter,
    output logic             permutation_start,
    output logic             permutation_ready,
    output logic             round_en,
    output logic [CTR_W-1:0] round_idx,
    output logic             busy,
    output logic             err
);
    import perm_pkg::*;

    perm_seq_state_t  state;
    logic [CTR_W-1:0] rounds_q;
    logic [CTR_W-1:0] rounds_sat;
    logic             accept;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        rounds_sat = req_rounds;
        if (req_rounds > CTR_W'(MAX_ROUNDS)) rounds_sat = CTR_W'(MAX_ROUNDS);
    end

    // Offset so the final round always uses constant index MAX_ROUNDS-1.
    always_comb begin
        round_idx = '0;
        if (round_en) round_idx = CTR_W'(MAX_ROUNDS) - rounds_q + counter;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            rounds_q          <= '0;
            permutation_start <= 1'b0;
            permutation_ready <= 1'b0;
            round_en          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    permutation_ready <= 1'b0;
                    if (accept) begin
                        rounds_q <= rounds_sat;
                        if (rounds_sat == '0) begin
                            state             <= DONE;
                            permutation_ready <= 1'b1;
                        end else begin
                            state             <= RUN;
                            permutation_start <= 1'b1;
                            round_en          <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state             <= IDLE;
                        permutation_start <= 1'b0;
                        round_en          <= 1'b0;
                    end else if (counter == rounds_q - CTR_W'(1)) begin
                        state             <= DONE;
                        permutation_start <= 1'b0;
                        round_en          <= 1'b0;
                        permutation_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state             <= IDLE;
                    permutation_ready <= 1'b0;
                end
                default: begin
                    state             <= IDLE;
                    permutation_start <= 1'b0;
                    permutation_ready <= 1'b0;
                    round_en          <= 1'b0;
                end
            endcase
        end
    end

`ifdef PERM_SEQ_COUNTER_CHECK_EN
    logic [CTR_W-1:0] shadow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= '0;
            err    <= 1'b0;
        end else begin
            if (accept)
                shadow <= '0;
            else if (state == RUN)
                shadow <= shadow + CTR_W'(1);
            if ((state == RUN && counter != shadow) || (state == IDLE && counter != '0))
                err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_permutation_sequencer.sv
// Self-checking bench for permutation_sequencer with a behavioural round counter.
module tb_permutation_sequencer;

    localparam int W   = 5;
    localparam int MAX = 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_rounds = '0;
    logic         abort = 1'b0;
    logic [W-1:0] counter;
    logic         permutation_start;
    logic         permutation_ready;
    logic         round_en;
    logic [W-1:0] round_idx;
    logic         busy;
    logic         err;

    logic [W-1:0] cnt_q;
    logic         stuck = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // External round counter: counts while start is high, clears otherwise.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= permutation_start ? cnt_q + 5'd1 : 5'd0;
    end
    assign counter = stuck ? 5'd3 : cnt_q;

    permutation_sequencer #(.CTR_W(W), .MAX_ROUNDS(MAX)) dut (
        .clk(clk),
        .rst(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rounds(req_rounds),
        .abort(abort),
        .counter(counter),
        .permutation_start(permutation_start),
        .permutation_ready(permutation_ready),
        .round_en(round_en),
        .round_idx(round_idx),
        .busy(busy),
        .err(err)
    );

    function automatic int eff_rounds(input int r);
        return (r > MAX) ? MAX : r;
    endfunction

    // Issue one request and check every cycle until back in IDLE.
    task automatic exercise(input string name, input int rounds, input int abort_at);
        int e;
        bit aborted;
        e = eff_rounds(rounds);
        aborted = 0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_before_accept got=%0b want=1", name, req_ready);
        end
        req_valid  = 1'b1;
        req_rounds = W'(rounds);
        abort      = 1'($urandom_range(0, 1));
        @(negedge clk);
        req_valid  = 1'b0;
        abort      = 1'b0;
        req_rounds = W'($urandom);
        if (e == 0) begin
            total++;
            if (permutation_ready !== 1'b1 || permutation_start !== 1'b0 || round_en !== 1'b0 ||
                busy !== 1'b1 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s zero_done rdy=%0b start=%0b en=%0b busy=%0b req_ready=%0b want 1,0,0,1,0",
                         name, permutation_ready, permutation_start, round_en, busy, req_ready);
            end
        end else begin
            for (int c = 1; c <= e; c++) begin
                total++;
                if (permutation_start !== 1'b1 || round_en !== 1'b1 || permutation_ready !== 1'b0 ||
                    busy !== 1'b1 || req_ready !== 1'b0 || round_idx !== W'(MAX - e + c - 1)) begin
                    bad++;
                    $display("FAIL %s run_cycle%0d start=%0b en=%0b rdy=%0b busy=%0b req_ready=%0b idx=%0d want 1,1,0,1,0 idx=%0d",
                             name, c, permutation_start, round_en, permutation_ready, busy, req_ready,
                             round_idx, MAX - e + c - 1);
                end
                if (c == abort_at) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    aborted = 1;
                    total++;
                    if (req_ready !== 1'b1 || busy !== 1'b0 || permutation_start !== 1'b0 ||
                        permutation_ready !== 1'b0 || round_en !== 1'b0 || round_idx !== 5'd0) begin
                        bad++;
                        $display("FAIL %s after_abort req_ready=%0b busy=%0b start=%0b rdy=%0b en=%0b idx=%0d want 1,0,0,0,0,0",
                                 name, req_ready, busy, permutation_start, permutation_ready, round_en, round_idx);
                    end
                    break;
                end
                @(negedge clk);
            end
            if (!aborted) begin
                total++;
                if (permutation_ready !== 1'b1 || permutation_start !== 1'b0 || round_en !== 1'b0 ||
                    round_idx !== 5'd0 || req_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL %s done rdy=%0b start=%0b en=%0b idx=%0d req_ready=%0b want 1,0,0,0,0",
                             name, permutation_ready, permutation_start, round_en, round_idx, req_ready);
                end
            end
        end
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || permutation_ready !== 1'b0 || busy !== 1'b0 || counter !== 5'd0) begin
            bad++;
            $display("FAIL %s idle_after req_ready=%0b rdy=%0b busy=%0b counter=%0d want 1,0,0,0",
                     name, req_ready, permutation_ready, busy, counter);
        end
`ifndef PERM_SEQ_COUNTER_CHECK_EN
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL %s err_tied got=%0b want=0", name, err);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || permutation_start !== 1'b0 || permutation_ready !== 1'b0 ||
            round_en !== 1'b0 || round_idx !== 5'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_values req_ready=%0b busy=%0b start=%0b rdy=%0b en=%0b idx=%0d err=%0b",
                     req_ready, busy, permutation_start, permutation_ready, round_en, round_idx, err);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full();       exercise("full12", 12, 0); endtask
    task automatic test_short();      exercise("short6", 6, 0);  endtask
    task automatic test_zero();       exercise("zero", 0, 0);    endtask
    task automatic test_saturate();   exercise("sat20", 20, 0);  endtask

    task automatic test_abort();
        exercise("abort8", 8, 3);
        @(negedge clk);
        exercise("after_abort8", 8, 0);
    endtask

    task automatic test_back_to_back();
        int cycles;
        @(negedge clk);
        req_valid  = 1'b1;
        req_rounds = 5'd12;
        @(negedge clk);
        req_rounds = 5'd8;
        cycles = 1;
        while (req_ready !== 1'b1 && cycles < 40) begin
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL b2b_busy cycle%0d got=%0b want=1", cycles, busy);
            end
            @(negedge clk);
            cycles++;
        end
        total++;
        if (cycles != 14) begin
            bad++;
            $display("FAIL b2b_second_accept got=%0d want=14 cycles", cycles);
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            total++;
            if (round_en !== 1'b1 || round_idx !== W'(MAX - 8 + c - 1) || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL b2b_run8 cycle%0d en=%0b idx=%0d req_ready=%0b want 1,%0d,0",
                         c, round_en, round_idx, req_ready, MAX - 8 + c - 1);
            end
            @(negedge clk);
        end
        total++;
        if (permutation_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done got=%0b want=1", permutation_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        req_valid  = 1'b1;
        req_rounds = 5'd12;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || permutation_start !== 1'b0 || permutation_ready !== 1'b0 ||
            round_en !== 1'b0 || round_idx !== 5'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_run req_ready=%0b busy=%0b start=%0b rdy=%0b en=%0b idx=%0d err=%0b",
                     req_ready, busy, permutation_start, permutation_ready, round_en, round_idx, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exercise("post_reset12", 12, 0);
    endtask

    task automatic test_random();
        int r;
        int a;
        for (int i = 0; i < 20; i++) begin
            r = $urandom_range(0, 31);
            a = 0;
            if (eff_rounds(r) > 0 && $urandom_range(0, 3) == 0) a = $urandom_range(1, eff_rounds(r));
            exercise("random", r, a);
`ifdef PERM_SEQ_COUNTER_CHECK_EN
            @(negedge clk);
`endif
        end
    endtask

`ifdef PERM_SEQ_COUNTER_CHECK_EN
    task automatic test_counter_fault();
        test_reset();
        @(negedge clk);
        stuck      = 1'b1;
        req_valid  = 1'b1;
        req_rounds = 5'd12;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL fault_err_set got=%0b want=1", err);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL fault_err_sticky err=%0b busy=%0b want 1,0", err, busy);
        end
        test_reset();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL fault_err_cleared got=%0b want=0", err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full();
        test_short();
        test_zero();
        test_saturate();
        test_abort();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
`ifdef PERM_SEQ_COUNTER_CHECK_EN
        test_counter_fault();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
